// File: rtl/alu_param_pkg.sv
// Shared opcodes, FSM encoding and flag bit positions
// for the parametrised handshaked ALU.
package alu_param_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_NOT  = 5;
  localparam int OP_SHL  = 6;
  localparam int OP_SHR  = 7;
  localparam int OP_SAR  = 8;
  localparam int OP_MUL  = 9;
  localparam int OP_PASS = 10;
  localparam int N_OPS   = 11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  localparam int FL_Z = 0;
  localparam int FL_N = 1;
  localparam int FL_V = 2;
  localparam int FL_C = 3;

endpackage

// File: rtl/alu_param_if.sv
// Controller-to-ALU request/result bundle with
// cs/ready/done handshake.
interface alu_param_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
);
  logic             cs;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] bus_hi;
  logic [3:0]       flags;
  logic             err;
  logic             ready;
  logic             done;

  modport master (
    output cs, op, a, b,
    input  bus, bus_hi, flags, err, ready, done
  );

  modport slave (
    input  cs, op, a, b,
    output bus, bus_hi, flags, err, ready, done
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-add multiplier, one
// partial product per clock.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_next;

  // r_lo starts as the multiplier and fills with
  // product bits as it shifts right.
  assign w_sum  = {1'b0, r_hi}
                + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_next = {w_sum, r_lo[WIDTH-1:1]};

  // o_done marks the final iteration; the product
  // is valid on o_product during that same cycle.
  assign o_busy    = r_busy;
  assign o_done    = r_busy
                  && (r_cnt == CW'(WIDTH - 1));
  assign o_product = w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_start && !r_busy) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= i_a;
      r_hi    <= '0;
      r_lo    <= i_b;
    end else if (r_busy) begin
      {r_hi, r_lo} <= w_next;
      r_cnt        <= r_cnt + 1'b1;
      if (o_done)
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_param.sv
// Handshaked multi-op ALU: single-cycle logic/arith/
// shift ops plus a WIDTH-cycle unsigned multiply.
module alu_param
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rst_n,
  alu_param_if.slave io
);

  localparam int MSB = WIDTH - 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_bus;
  logic [WIDTH-1:0] r_bus_hi;
  logic [3:0]       r_flags;
  logic             r_err;
  logic             r_done;

  logic               w_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [N_OPS-1:0]   w_sel;
  logic [SH_W-1:0]    w_sh;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sar;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_ill;
  logic [3:0]         w_ex_fl;
  logic [3:0]         w_mul_fl;

  assign w_ready  = (r_state == S_IDLE)
                 && !w_mul_busy;
  assign w_accept = w_ready && io.cs;
  assign w_is_mul = (io.op == OP_W'(OP_MUL));

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && w_is_mul),
    .i_a       (io.a),
    .i_b       (io.b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  assign w_mul_lo = w_prod[WIDTH-1:0];
  assign w_mul_hi = w_prod[2*WIDTH-1:WIDTH];

  // Extra bit on each shift catches the last bit
  // shifted out; it stays 0 for a zero amount.
  assign w_sh  = r_b[SH_W-1:0];
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
  assign w_shl = {1'b0, r_a} << w_sh;
  assign w_shr = {r_a, 1'b0} >> w_sh;
  assign w_sar = $signed({r_a, 1'b0}) >>> w_sh;

  always_comb begin
    for (int i = 0; i < N_OPS; i++)
      w_sel[i] = (r_op == OP_W'(i));
  end

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    unique case (1'b1)
      w_sel[OP_ADD]: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_a[MSB] == r_b[MSB])
             && (w_add[MSB] != r_a[MSB]);
      end
      w_sel[OP_SUB]: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_a[MSB] != r_b[MSB])
             && (w_sub[MSB] != r_a[MSB]);
      end
      w_sel[OP_AND]:  w_res = r_a & r_b;
      w_sel[OP_OR]:   w_res = r_a | r_b;
      w_sel[OP_XOR]:  w_res = r_a ^ r_b;
      w_sel[OP_NOT]:  w_res = ~r_a;
      w_sel[OP_SHL]:  {w_c, w_res} = w_shl;
      w_sel[OP_SHR]:  {w_res, w_c} = w_shr;
      w_sel[OP_SAR]:  {w_res, w_c} = w_sar;
      w_sel[OP_MUL]:  w_res = '0;
      w_sel[OP_PASS]: w_res = r_a;
      default:        w_ill = 1'b1;
    endcase
  end

  // An illegal op reports all-zero flags, so zero
  // must be masked even though bus is 0.
  always_comb begin
    w_ex_fl       = '0;
    w_ex_fl[FL_C] = w_c;
    w_ex_fl[FL_V] = w_v;
    w_ex_fl[FL_N] = w_res[MSB];
    w_ex_fl[FL_Z] = !w_ill && (w_res == '0);
  end

  always_comb begin
    w_mul_fl       = '0;
    w_mul_fl[FL_C] = |w_mul_hi;
    w_mul_fl[FL_N] = w_mul_lo[MSB];
    w_mul_fl[FL_Z] = (w_prod == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_bus    <= '0;
      r_bus_hi <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= io.a;
            r_b     <= io.b;
            r_op    <= io.op;
            r_state <= w_is_mul ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_bus    <= w_res;
          r_bus_hi <= '0;
          r_flags  <= w_ex_fl;
          r_err    <= w_ill;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        S_MUL: begin
          if (w_mul_done) begin
            r_bus    <= w_mul_lo;
            r_bus_hi <= w_mul_hi;
            r_flags  <= w_mul_fl;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.bus    = r_bus;
  assign io.bus_hi = r_bus_hi;
  assign io.flags  = r_flags;
  assign io.err    = r_err;
  assign io.ready  = w_ready;
  assign io.done   = r_done;

endmodule

// File: tb/tb_alu_param.sv
// Bench for alu_param: 16- and 8-bit instances checked
// against an integer-arithmetic reference model.
module tb_alu_param;
  import alu_param_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_param_if #(.WIDTH(16), .OP_W(4)) i16 ();
  alu_param_if #(.WIDTH(8),  .OP_W(4)) i8  ();

  alu_param #(.WIDTH(16), .OP_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .io(i16)
  );
  alu_param #(.WIDTH(8), .OP_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .io(i8)
  );

  typedef struct {
    logic [15:0] bus;
    logic [15:0] hi;
    logic [3:0]  fl;
    logic        err;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic per opcode.
  function automatic res_t model(input int w,
      input int op, input longint ai,
      input longint bi);
    res_t r;
    longint mask, half, a, b, sa, sb, x, lo, hi;
    int sh;
    bit c, v, err;
    mask = (64'sd1 << w) - 1;
    half = 64'sd1 << (w - 1);
    a  = ai & mask;
    b  = bi & mask;
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    sh = int'(b % w);
    lo = 0; hi = 0; c = 0; v = 0; err = 0;
    case (op)
      0: begin
        x = a + b; lo = x; c = (x > mask);
        x = sa + sb; v = (x >= half) || (x < -half);
      end
      1: begin
        lo = a - b; c = (a < b);
        x = sa - sb; v = (x >= half) || (x < -half);
      end
      2: lo = a & b;
      3: lo = a | b;
      4: lo = a ^ b;
      5: lo = ~a;
      6: begin
        lo = a << sh;
        c = (sh != 0) && (((a >> (w - sh)) & 1) != 0);
      end
      7: begin
        lo = a >> sh;
        c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0);
      end
      8: begin
        lo = sa >>> sh;
        c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0);
      end
      9: begin
        x = a * b; lo = x; hi = x >> w;
        c = ((hi & mask) != 0);
      end
      10: lo = a;
      default: err = 1;
    endcase
    lo &= mask;
    hi &= mask;
    r.bus = 16'(lo);
    r.hi  = 16'(hi);
    r.err = err;
    if (err) r.fl = 4'h0;
    else r.fl = {c, v, 1'(lo >> (w - 1)),
                 (lo == 0) && (hi == 0)};
    return r;
  endfunction

  task automatic drive(input int w, input bit cs,
      input int op, input longint a, input longint b);
    if (w == 8) begin
      i8.cs = cs; i8.op = 4'(op);
      i8.a = 8'(a); i8.b = 8'(b);
    end else begin
      i16.cs = cs; i16.op = 4'(op);
      i16.a = 16'(a); i16.b = 16'(b);
    end
  endtask

  function automatic bit rdy(input int w);
    return (w == 8) ? i8.ready : i16.ready;
  endfunction

  function automatic bit dn(input int w);
    return (w == 8) ? i8.done : i16.done;
  endfunction

  function automatic res_t obs(input int w);
    res_t r;
    if (w == 8) begin
      r.bus = {8'h0, i8.bus};
      r.hi  = {8'h0, i8.bus_hi};
      r.fl  = i8.flags;
      r.err = i8.err;
    end else begin
      r.bus = i16.bus;
      r.hi  = i16.bus_hi;
      r.fl  = i16.flags;
      r.err = i16.err;
    end
    return r;
  endfunction

  task automatic cmp(input string tag,
                     input int w, input res_t e);
    res_t g;
    g = obs(w);
    check({tag, ".bus"},   32'(g.bus), 32'(e.bus));
    check({tag, ".hi"},    32'(g.hi),  32'(e.hi));
    check({tag, ".flags"}, 32'(g.fl),  32'(e.fl));
    check({tag, ".err"},   32'(g.err), 32'(e.err));
  endtask

  task automatic run_op(input int w, input int op,
      input longint a, input longint b,
      input bit noise, input string tag);
    res_t e;
    int lat;
    int want;
    bit busy_ok;
    e    = model(w, op, a, b);
    want = (op == OP_MUL) ? w : 1;
    check({tag, ".ready"}, 32'(rdy(w)), 1);
    drive(w, 1, op, a, b);
    @(posedge clk); #1;
    drive(w, 0, $urandom_range(0, 15),
          $urandom, $urandom);
    check({tag, ".busy"}, 32'(rdy(w)), 0);
    lat = 0;
    busy_ok = 1;
    while (lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (dn(w)) break;
      busy_ok &= !rdy(w);
      if (noise)
        drive(w, 1'($urandom_range(0, 1)),
              $urandom_range(0, 15),
              $urandom, $urandom);
    end
    drive(w, 0, 0, 0, 0);
    check({tag, ".latency"}, 32'(lat), 32'(want));
    check({tag, ".held_busy"}, 32'(busy_ok), 1);
    cmp(tag, w, e);
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'(dn(w)), 0);
  endtask

  initial begin
    res_t e;
    int lat;
    bit seen;
    drive(16, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0);
    #2;
    e = '{bus: 16'h0, hi: 16'h0, fl: 4'h0, err: 1'b0};
    check("rst16.ready", 32'(rdy(16)), 1);
    check("rst16.done",  32'(dn(16)), 0);
    cmp("rst16", 16, e);
    check("rst8.ready", 32'(rdy(8)), 1);
    cmp("rst8", 8, e);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16, OP_ADD, 'h7FFF, 'h0001, 0, "add_ovf");

    // Abort a multiply part-way with async reset.
    drive(16, 1, OP_MUL, 'h00FF, 'h0003);
    @(posedge clk); #1;
    drive(16, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("rstmul.busy", 32'(rdy(16)), 0);
    rst_n = 1'b0;
    #1;
    e = '{bus: 16'h0, hi: 16'h0, fl: 4'h0, err: 1'b0};
    check("rstmul.ready", 32'(rdy(16)), 1);
    check("rstmul.done",  32'(dn(16)), 0);
    cmp("rstmul", 16, e);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (24) begin
      @(posedge clk); #1;
      seen |= dn(16);
    end
    check("rstmul.no_done", 32'(seen), 0);

    run_op(16, OP_SUB, 'h0005, 'h0005, 0, "sub_zero");
    run_op(16, OP_SUB, 'h0003, 'h0005, 0, "sub_brw");
    run_op(16, OP_SAR, 'h8004, 'h0002, 0, "sar");
    run_op(16, OP_SHL, 'hC000, 'h0001, 0, "shl");
    run_op(16, OP_SHR, $urandom, 'h0010, 0, "shr0");
    run_op(16, OP_MUL, 'hFFFF, 'hFFFF, 1, "mul_max");
    run_op(16, 12, 'h1234, 'h5678, 0, "illegal");

    // cs held high: next accept on the edge after done.
    drive(16, 1, OP_AND, 'hF0F0, 'h0FF0);
    e = model(16, OP_AND, 'hF0F0, 'h0FF0);
    lat = 0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (dn(16)) break;
    end
    check("b2b.lat1", 32'(lat), 2);
    cmp("b2b.and", 16, e);
    check("b2b.ready", 32'(rdy(16)), 1);
    drive(16, 1, OP_XOR, 'h1234, 'h00FF);
    e = model(16, OP_XOR, 'h1234, 'h00FF);
    @(posedge clk); #1;
    check("b2b.acc_ready", 32'(rdy(16)), 0);
    check("b2b.acc_done",  32'(dn(16)), 0);
    @(posedge clk); #1;
    drive(16, 0, 0, 0, 0);
    check("b2b.done2", 32'(dn(16)), 1);
    cmp("b2b.xor", 16, e);
    @(posedge clk); #1;

    run_op(8, OP_ADD, 'h7F, 'h01, 0, "w8_add");
    run_op(8, OP_SUB, 'h03, 'h05, 0, "w8_sub");
    run_op(8, OP_SAR, 'h84, 'h03, 0, "w8_sar");
    run_op(8, OP_MUL, 'hFF, 'hFF, 1, "w8_mul");
    run_op(8, 15, 'h12, 'h34, 0, "w8_ill");

    for (int i = 0; i < 40; i++)
      run_op(16, $urandom_range(0, 15),
             $urandom & 'hFFFF, $urandom & 'hFFFF,
             1'($urandom_range(0, 1)),
             $sformatf("rnd16_%0d", i));
    for (int i = 0; i < 30; i++)
      run_op(8, $urandom_range(0, 15),
             $urandom & 'hFF, $urandom & 'hFF,
             0, $sformatf("rnd8_%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
